// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - data-port word RAM responder with an arbitrated host port
// Optional feature macro: ACCESS_CNT_EN (saturating RdCount/WrCount/HostCount outputs).
module data_mem_responder #(
  parameter int DEPTH         = 1024,
  parameter int AW            = $clog2(DEPTH),
  parameter int HOST_WAIT_MAX = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          MemWrite,
  input  logic          MemRead,
  input  logic [31:0]   Addr,
  input  logic [31:0]   WriteData,
  output logic [31:0]   ReadData,
  output logic          ReadValid,
  output logic          AddrError,
  output logic          StallReq,
  input  logic          HostReq,
  input  logic          HostWe,
  input  logic [AW-1:0] HostAddr,
  input  logic [31:0]   HostWData,
  output logic          HostGnt,
  output logic [31:0]   HostRData,
  output logic          HostRValid
`ifdef ACCESS_CNT_EN
  ,
  output logic [31:0]   RdCount,
  output logic [31:0]   WrCount,
  output logic [31:0]   HostCount
`endif
);

  typedef enum logic [1:0] {IDLE, WAIT, STALL, RESP} state_t;

  localparam logic [7:0] WAIT_MAX = 8'(HOST_WAIT_MAX);

  state_t      state;
  logic [7:0]  waitCnt;
  logic [31:0] mem [DEPTH];

  logic [AW-1:0] procIdx;
  logic          procBusy;
  logic          procLoad;
  logic          procBad;
  logic          hostGrant;

  assign procIdx   = Addr[AW+1:2];
  assign procBusy  = MemWrite | MemRead;
  assign procLoad  = MemRead & ~MemWrite;
  assign procBad   = (Addr[1:0] != 2'b00) | ((Addr >> (AW + 2)) != 32'd0);
  // Processor has absolute priority: the host only gets cycles the processor leaves empty.
  assign hostGrant = HostReq & ~procBusy & ~reset;
  assign HostGnt   = hostGrant;

  always_ff @(posedge clk) begin
    if (!reset && MemWrite && !procBad) begin
      mem[procIdx] <= WriteData;
    end else if (hostGrant && HostWe) begin
      mem[HostAddr] <= HostWData;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ReadData   <= '0;
      ReadValid  <= 1'b0;
      AddrError  <= 1'b0;
      StallReq   <= 1'b0;
      HostRData  <= '0;
      HostRValid <= 1'b0;
      state      <= IDLE;
      waitCnt    <= '0;
    end else begin
      ReadValid  <= procLoad;
      AddrError  <= procBusy & procBad;
      if (procLoad) begin
        ReadData <= procBad ? 32'd0 : mem[procIdx];
      end
      HostRValid <= hostGrant & ~HostWe;
      if (hostGrant && !HostWe) begin
        HostRData <= mem[HostAddr];
      end

      case (state)
        IDLE, RESP: begin
          if (hostGrant) begin
            state <= HostWe ? IDLE : RESP;
          end else if (HostReq) begin
            waitCnt <= 8'd1;
            if (WAIT_MAX == 8'd1) begin
              state    <= STALL;
              StallReq <= 1'b1;
            end else begin
              state <= WAIT;
            end
          end else begin
            state <= IDLE;
          end
        end
        WAIT, STALL: begin
          // A withdrawn request releases the processor rather than stalling it forever.
          if (!HostReq) begin
            state    <= IDLE;
            waitCnt  <= '0;
            StallReq <= 1'b0;
          end else if (hostGrant) begin
            state    <= HostWe ? IDLE : RESP;
            waitCnt  <= '0;
            StallReq <= 1'b0;
          end else if (state == WAIT) begin
            waitCnt <= waitCnt + 8'd1;
            if (waitCnt + 8'd1 == WAIT_MAX) begin
              state    <= STALL;
              StallReq <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ACCESS_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      RdCount   <= '0;
      WrCount   <= '0;
      HostCount <= '0;
    end else begin
      if (procLoad && RdCount != 32'hFFFF_FFFF) RdCount <= RdCount + 32'd1;
      if (MemWrite && WrCount != 32'hFFFF_FFFF) WrCount <= WrCount + 32'd1;
      if (hostGrant && HostCount != 32'hFFFF_FFFF) HostCount <= HostCount + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - randomized self-checking bench for data_mem_responder
module tb_data_mem_responder;
  localparam int DEPTH = 1024;
  localparam int AW    = 10;
  localparam int HWM   = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          MemWrite, MemRead;
  logic [31:0]   Addr, WriteData;
  logic [31:0]   ReadData;
  logic          ReadValid, AddrError, StallReq;
  logic          HostReq, HostWe;
  logic [AW-1:0] HostAddr;
  logic [31:0]   HostWData;
  logic          HostGnt;
  logic [31:0]   HostRData;
  logic          HostRValid;

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH(DEPTH), .HOST_WAIT_MAX(HWM)) dut (
    .clk(clk), .reset(reset),
    .MemWrite(MemWrite), .MemRead(MemRead), .Addr(Addr), .WriteData(WriteData),
    .ReadData(ReadData), .ReadValid(ReadValid), .AddrError(AddrError), .StallReq(StallReq),
    .HostReq(HostReq), .HostWe(HostWe), .HostAddr(HostAddr), .HostWData(HostWData),
    .HostGnt(HostGnt), .HostRData(HostRData), .HostRValid(HostRValid)
  );

  int checks = 0;
  int failures = 0;

  // Reference state: word contents plus how long the current host request has gone unserved.
  logic [31:0] refMem [DEPTH];
  int          waitCycles = 0;
  logic        expRV = 0, expAE = 0, expHRV = 0, expStall = 0;
  logic [31:0] expRD = 0, expHRD = 0;
  logic        lastGnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic mw, input logic mr, input logic [31:0] a, input logic [31:0] wd,
                     input logic hr, input logic hwe, input logic [AW-1:0] ha, input logic [31:0] hwd);
    logic bad;
    int   idx;
    MemWrite = mw; MemRead = mr; Addr = a; WriteData = wd;
    HostReq = hr; HostWe = hwe; HostAddr = ha; HostWData = hwd;
    #1;
    lastGnt = hr && !(mw || mr);
    check("HostGnt", HostGnt, lastGnt);
    bad = (a % 4 != 0) || (a >= DEPTH * 4);
    idx = int'(a / 4) % DEPTH;
    expRV = mr && !mw;
    if (expRV) expRD = bad ? 32'd0 : refMem[idx];
    expAE = (mw || mr) && bad;
    expHRV = lastGnt && !hwe;
    if (expHRV) expHRD = refMem[ha];
    if (mw && !bad) refMem[idx] = wd;
    if (lastGnt && hwe) refMem[ha] = hwd;
    if (lastGnt || !hr) waitCycles = 0;
    else waitCycles++;
    expStall = waitCycles >= HWM;
    @(posedge clk);
    #1;
    check("ReadValid", ReadValid, expRV);
    if (expRV) check("ReadData", ReadData, expRD);
    check("AddrError", AddrError, expAE);
    check("HostRValid", HostRValid, expHRV);
    if (expHRV) check("HostRData", HostRData, expHRD);
    check("StallReq", StallReq, expStall);
  endtask

  task automatic idle();
    cyc(0, 0, 32'd0, 32'd0, 0, 0, '0, 32'd0);
  endtask

  task automatic checkAllZero(input string tag);
    check({tag, "_ReadData"}, ReadData, 0);
    check({tag, "_ReadValid"}, ReadValid, 0);
    check({tag, "_AddrError"}, AddrError, 0);
    check({tag, "_StallReq"}, StallReq, 0);
    check({tag, "_HostGnt"}, HostGnt, 0);
    check({tag, "_HostRData"}, HostRData, 0);
    check({tag, "_HostRValid"}, HostRValid, 0);
  endtask

  initial begin
    int          firstStall;
    logic        pend, pWe;
    logic [AW-1:0] pAddr;
    logic [31:0] pData, a;
    logic        mw, mr;
    int          r;

    reset = 1;
    MemWrite = 0; MemRead = 0; Addr = 0; WriteData = 0;
    HostReq = 1; HostWe = 0; HostAddr = 0; HostWData = 0;
    repeat (2) @(posedge clk);
    #1;
    checkAllZero("reset");
    reset = 0;

    for (int w = 0; w < 16; w++) cyc(1, 0, w * 4, $urandom, 0, 0, '0, 0);
    cyc(1, 0, (DEPTH - 1) * 4, 32'hA5A5_0001, 0, 0, '0, 0);

    cyc(1, 0, 32'h10, 32'hDEAD_BEEF, 0, 0, '0, 0);
    cyc(0, 1, 32'h10, 0, 0, 0, '0, 0);
    check("raw_data", ReadData, 32'hDEAD_BEEF);
    check("raw_err", AddrError, 0);

    cyc(0, 1, 32'h13, 0, 0, 0, '0, 0);
    check("misalign_data", ReadData, 0);
    check("misalign_err", AddrError, 1);
    cyc(0, 1, DEPTH * 4, 0, 0, 0, '0, 0);
    check("range_err", AddrError, 1);
    cyc(1, 0, 32'h13, 32'h0BAD_0BAD, 0, 0, '0, 0);
    check("store_err", AddrError, 1);
    cyc(0, 1, 32'h10, 0, 0, 0, '0, 0);
    check("alias_kept", ReadData, 32'hDEAD_BEEF);
    cyc(0, 1, (DEPTH - 1) * 4, 0, 0, 0, '0, 0);
    check("top_word", ReadData, 32'hA5A5_0001);
    cyc(1, 1, 32'h20, 32'h5555_AAAA, 0, 0, '0, 0);
    check("both_no_rv", ReadValid, 0);

    cyc(0, 0, 0, 0, 1, 1, AW'(5), 32'h1234);
    check("host_wr_gnt", lastGnt, 1);
    cyc(0, 1, 32'h14, 0, 0, 0, '0, 0);
    check("host_wr_data", ReadData, 32'h0000_1234);

    firstStall = -1;
    for (int i = 0; i < HWM + 3; i++) begin
      cyc(0, 1, ($urandom % 16) * 4, 0, 1, 0, AW'(3), 0);
      if (StallReq && firstStall < 0) firstStall = i + 1;
    end
    check("stall_latency", firstStall, HWM);
    cyc(0, 0, 0, 0, 1, 0, AW'(3), 0);
    check("stall_drop", StallReq, 0);
    idle();

    cyc(1, 0, 7 * 4, 32'hCAFE_F00D, 1, 0, AW'(7), 0);
    cyc(0, 0, 0, 0, 1, 0, AW'(7), 0);
    check("conflict_rdata", HostRData, 32'hCAFE_F00D);
    check("conflict_rvalid", HostRValid, 1);

    cyc(0, 0, 0, 0, 1, 0, AW'(5), 0);
    reset = 1;
    HostReq = 1; MemRead = 0;
    #1;
    checkAllZero("resp_reset");
    MemRead = 1; Addr = 32'h10; HostReq = 0;
    @(posedge clk);
    #1;
    check("reset_edge_rv", ReadValid, 0);
    check("reset_edge_hrv", HostRValid, 0);
    reset = 0;
    MemRead = 0;
    waitCycles = 0; expRD = 0; expHRD = 0;
    cyc(0, 1, 32'h10, 0, 0, 0, '0, 0);
    check("post_reset_data", ReadData, 32'hDEAD_BEEF);

    pend = 0; pWe = 0; pAddr = '0; pData = 0;
    for (int n = 0; n < 2000; n++) begin
      if (!pend && ($urandom % 3 == 0)) begin
        pend = 1;
        pWe = $urandom % 2;
        pAddr = AW'($urandom % 16);
        pData = $urandom;
      end
      r = $urandom % 10;
      a = ($urandom % 16) * 4;
      if (r == 0) a = a + 1 + ($urandom % 3);
      else if (r == 1) a = DEPTH * 4 + ($urandom % 64) * 4;
      r = $urandom % 8;
      mw = (r == 1 || r == 2 || r == 7);
      mr = (r == 3 || r == 4 || r == 7);
      if (expStall && ($urandom % 2 == 0)) begin
        mw = 0; mr = 0;
      end
      cyc(mw, mr, a, $urandom, pend, pWe, pAddr, pData);
      if (lastGnt) pend = 0;
    end
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
